// File: rtl/store_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package   : store_pkg                                                 |
// | Contents  : store op encodings, buffered entry layout, pointer width  |
// | Revision  : 1.0 - initial release                                     |
// +-----------------------------------------------------------------------+
package store_pkg;

  localparam logic [1:0] ST_W = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_B = 2'b10;

  // One buffered store: word address, lane enables, lane-replicated data
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } entry_t;

  // Pointer width for a power-of-two depth; at least one bit
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_lane_pack.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module    : store_lane_pack                                           |
// | Function  : packs a register value into byte lanes with enables.      |
// |             Alignment checking enabled by STORE_ALIGN_CHECK_EN.       |
// | Revision  : 1.0 - initial release                                     |
// +-----------------------------------------------------------------------+
module store_lane_pack
  import store_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic        drop_o
);

  // Lane placement: narrow values are replicated so any enabled lane holds the right byte
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = data_i;
    misaligned_o = 1'b0;
    drop_o       = 1'b0;
    case (op_i)
      ST_W: begin
        be_o    = 4'b1111;
        wdata_o = data_i;
`ifdef STORE_ALIGN_CHECK_EN
        misaligned_o = (addr_i != 2'b00);
`endif
      end
      ST_H: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{data_i[15:0]}};
`ifdef STORE_ALIGN_CHECK_EN
        misaligned_o = addr_i[0];
`endif
      end
      ST_B: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{data_i[7:0]}};
      end
      default: begin
        // Reserved op: handshake still completes but nothing is written
        drop_o = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module    : store_write_buffer                                        |
// | Function  : packs stores into byte lanes and queues them in an        |
// |             in-order FIFO drained over a valid/ready handshake.       |
// |             Optional macro STORE_ALIGN_CHECK_EN adds misalign_err.    |
// | Revision  : 1.0 - initial release                                     |
// +-----------------------------------------------------------------------+
module store_write_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        empty
`ifdef STORE_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  entry_t           entries_q [DEPTH];

  logic [3:0]  pack_be;
  logic [31:0] pack_wdata;
  logic        pack_misaligned;
  logic        pack_drop;
  logic        accept;
  logic        enq;
  logic        deq;
  entry_t      new_entry;
  entry_t      head;

  store_lane_pack u_pack (
    .op_i         (req_op),
    .addr_i       (req_addr[1:0]),
    .data_i       (req_data),
    .be_o         (pack_be),
    .wdata_o      (pack_wdata),
    .misaligned_o (pack_misaligned),
    .drop_o       (pack_drop)
  );

  // Full blocks acceptance even if the head drains this cycle (no bypass path)
  assign req_ready = (count_q != FULL_CNT);
  assign mem_valid = (count_q != '0);
  assign empty     = (count_q == '0);
  assign accept    = req_valid && req_ready;
  assign enq       = accept && !pack_drop && !pack_misaligned;
  assign deq       = mem_valid && mem_ready;

  assign new_entry = '{addr: req_addr[31:2], be: pack_be, wdata: pack_wdata};
  assign head      = entries_q[rd_ptr_q];

  // Memory-side outputs are forced to zero whenever no entry is presented
  assign mem_addr  = mem_valid ? {head.addr, 2'b00} : 32'h0;
  assign mem_wdata = mem_valid ? head.wdata : 32'h0;
  assign mem_be    = mem_valid ? head.be : 4'b0000;

  // Pointer and occupancy next state; pointers wrap naturally at power-of-two depth
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards every queued entry at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Entry storage is data-only and deliberately left out of reset
  always_ff @(posedge clk) begin
    if (enq) entries_q[wr_ptr_q] <= new_entry;
  end

`ifdef STORE_ALIGN_CHECK_EN
  logic misalign_err_q;

  // One-cycle error pulse following the accept of a misaligned store
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_err_q <= 1'b0;
    else          misalign_err_q <= accept && pack_misaligned;
  end

  assign misalign_err = misalign_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module    : tb_store_write_buffer                                     |
// | Function  : self-checking bench for store_write_buffer (DEPTH=2),     |
// |             honours STORE_ALIGN_CHECK_EN when defined.                |
// | Revision  : 1.0 - initial release                                     |
// +-----------------------------------------------------------------------+
module tb_store_write_buffer;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        empty;
`ifdef STORE_ALIGN_CHECK_EN
  logic        misalign_err;
  logic        exp_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t model_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_enq;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .empty     (empty)
`ifdef STORE_ALIGN_CHECK_EN
    ,
    .misalign_err (misalign_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference packing: lane i carries byte (i mod size) of the value; the
  // enabled window starts at the access offset inside the word.
  function automatic void model_pack(input logic [1:0] op, input logic [31:0] addr,
                                     input logic [31:0] data, output logic [3:0] be,
                                     output logic [31:0] wd, output logic keep,
                                     output logic mis);
    int n;
    int off;
    int a;
    a    = int'(addr[1:0]);
    mis  = 1'b0;
    keep = 1'b1;
    n    = 4;
    off  = 0;
    case (op)
      2'd0: begin
        n = 4; off = 0;
`ifdef STORE_ALIGN_CHECK_EN
        mis = (a != 0);
`endif
      end
      2'd1: begin
        n = 2; off = a - (a % 2);
`ifdef STORE_ALIGN_CHECK_EN
        mis = (a % 2 == 1);
`endif
      end
      2'd2: begin
        n = 1; off = a;
      end
      default: keep = 1'b0;
    endcase
    be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = data[8*(i % n) +: 8];
    if (mis) keep = 1'b0;
  endfunction

  task automatic check_outputs();
    chk("req_ready", 32'(req_ready), 32'(model_q.size() < DEPTH));
    chk("empty",     32'(empty),     32'(model_q.size() == 0));
    chk("mem_valid", 32'(mem_valid), 32'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      chk("mem_addr",  mem_addr,      model_q[0].addr);
      chk("mem_be",    32'(mem_be),   32'(model_q[0].be));
      chk("mem_wdata", mem_wdata,     model_q[0].wdata);
    end else begin
      chk("mem_addr_idle",  mem_addr,    32'h0);
      chk("mem_be_idle",    32'(mem_be), 32'h0);
      chk("mem_wdata_idle", mem_wdata,   32'h0);
    end
`ifdef STORE_ALIGN_CHECK_EN
    chk("misalign_err", 32'(misalign_err), 32'(exp_err));
`endif
  endtask

  // One cycle: drive inputs at the falling edge, compare, then advance the model
  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic mr);
    logic [3:0]  be;
    logic [31:0] wd;
    logic        keep;
    logic        mis;
    logic        acc;
    @(negedge clk);
    req_valid = v;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    mem_ready = mr;
    #1;
    check_outputs();
    acc = v && (model_q.size() < DEPTH);
    model_pack(op, addr, data, be, wd, keep, mis);
    if (model_q.size() > 0 && mr) void'(model_q.pop_front());
    if (acc && keep) model_q.push_back('{addr: {addr[31:2], 2'b00}, be: be, wdata: wd});
`ifdef STORE_ALIGN_CHECK_EN
    exp_err = acc && mis;
`else
    if (mis) chk("model_mis_without_check", 32'(mis), 32'h0);
`endif
    cyc++;
  endtask

  vec_t vecs[8];

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    mem_ready = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
    exp_err   = 1'b0;
`endif

    vecs[0] = '{2'b10, 32'h0000_1003, 32'h1234_56AB, 1'b1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 1'b0};
    vecs[1] = '{2'b01, 32'h0000_2002, 32'hDEAD_BEEF, 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b0};
    vecs[2] = '{2'b00, 32'h0000_2004, 32'h0102_0304, 1'b1, 32'h0000_2004, 4'b1111, 32'h0102_0304, 1'b0};
    vecs[3] = '{2'b10, 32'h0000_0040, 32'h0000_00CD, 1'b1, 32'h0000_0040, 4'b0001, 32'hCDCD_CDCD, 1'b0};
    vecs[6] = '{2'b11, 32'h0000_6000, 32'h5555_5555, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b0};
    vecs[7] = '{2'b10, 32'h0000_7002, 32'h0000_0011, 1'b1, 32'h0000_7000, 4'b0100, 32'h1111_1111, 1'b0};
`ifdef STORE_ALIGN_CHECK_EN
    vecs[4] = '{2'b01, 32'h0000_5001, 32'h0000_A55A, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b1};
    vecs[5] = '{2'b00, 32'h0000_3002, 32'hCAFE_F00D, 1'b0, 32'h0,         4'b0000, 32'h0,         1'b1};
`else
    vecs[4] = '{2'b01, 32'h0000_5001, 32'h0000_A55A, 1'b1, 32'h0000_5000, 4'b0011, 32'hA55A_A55A, 1'b0};
    vecs[5] = '{2'b00, 32'h0000_3002, 32'hCAFE_F00D, 1'b1, 32'h0000_3000, 4'b1111, 32'hCAFE_F00D, 1'b0};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_empty",     32'(empty),     32'h1);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
`ifdef STORE_ALIGN_CHECK_EN
    chk("rst_misalign_err", 32'(misalign_err), 32'h0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Directed packing vectors, each drained one cycle after it appears
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].op, vecs[i].addr, vecs[i].data, 1'b1);
      step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
      chk($sformatf("vec%0d_valid", i), 32'(mem_valid), 32'(vecs[i].exp_enq));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(!vecs[i].exp_enq));
      if (vecs[i].exp_enq) begin
        chk($sformatf("vec%0d_addr", i),  mem_addr,      vecs[i].exp_addr);
        chk($sformatf("vec%0d_be", i),    32'(mem_be),   32'(vecs[i].exp_be));
        chk($sformatf("vec%0d_wdata", i), mem_wdata,     vecs[i].exp_wdata);
      end
`ifdef STORE_ALIGN_CHECK_EN
      chk($sformatf("vec%0d_err", i), 32'(misalign_err), 32'(vecs[i].exp_err));
`endif
    end
    step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

    // Fill with memory stalled, then full-and-draining cycle, then refill
    step(1'b1, 2'b00, 32'h0000_0100, 32'hAAAA_0001, 1'b0);
    step(1'b1, 2'b00, 32'h0000_0104, 32'hAAAA_0002, 1'b0);
    step(1'b1, 2'b00, 32'h0000_0108, 32'hAAAA_0003, 1'b0);
    chk("fill_ready_low", 32'(req_ready), 32'h0);
    step(1'b1, 2'b00, 32'h0000_0108, 32'hAAAA_0003, 1'b1);
    chk("full_drain_head", mem_addr, 32'h0000_0100);
    chk("full_drain_ready", 32'(req_ready), 32'h0);
    step(1'b1, 2'b00, 32'h0000_0108, 32'hAAAA_0003, 1'b1);
    chk("after_drain_ready", 32'(req_ready), 32'h1);
    chk("after_drain_head", mem_addr, 32'h0000_0104);
    step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("third_head", mem_addr, 32'h0000_0108);
    chk("third_wdata", mem_wdata, 32'hAAAA_0003);
    step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    chk("drained_empty", 32'(empty), 32'h1);

    // Mid-operation reset discards queued entries immediately
    step(1'b1, 2'b00, 32'h0000_0200, 32'hBBBB_0001, 1'b0);
    step(1'b1, 2'b00, 32'h0000_0204, 32'hBBBB_0002, 1'b0);
    step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    chk("prereset_valid", 32'(mem_valid), 32'h1);
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("midrst_mem_valid", 32'(mem_valid), 32'h0);
    chk("midrst_empty",     32'(empty),     32'h1);
    chk("midrst_req_ready", 32'(req_ready), 32'h1);
    chk("midrst_mem_addr",  mem_addr,       32'h0);
    model_q.delete();
`ifdef STORE_ALIGN_CHECK_EN
    exp_err = 1'b0;
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

    // Randomized traffic against the reference queue
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom, $urandom,
           $urandom_range(0, 9) < 6);
    end
    repeat (4) step(1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
